// File: rtl/uart_pkg.sv
// Shared UART types and constants: rx FSM states, stop-bit encoding, frame sizing.
// Used by both the receive and transmit paths.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int RX_WORD_W       = 9;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        STOP_1  = 2'b00,
        STOP_2  = 2'b01,
        STOP_3  = 2'b10,
        STOP_3B = 2'b11
    } stop_sel_e;

    function automatic logic [1:0] stop_count(input stop_sel_e sbit);
        case (sbit)
            STOP_1:  stop_count = 2'd1;
            STOP_2:  stop_count = 2'd2;
            default: stop_count = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional 16x baud tick: accumulator adds freq each clk and wraps at limit, ticking on wrap.
// Tick is registered (one clk after the wrapping sum); limit of zero freezes the accumulator.
module uart_baud_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] freq_i,
    input  logic [15:0] limit_i,
    output logic        tick_o
);

    logic [15:0] acc_q, acc_d;
    logic        tick_q, tick_d;
    logic [16:0] sum;
    logic [16:0] wrapped;

    always_comb begin
        sum     = {1'b0, acc_q} + {5'b0, freq_i};
        wrapped = sum - {1'b0, limit_i};
        acc_d   = acc_q;
        tick_d  = 1'b0;
        if (limit_i != 16'd0) begin
            if (sum >= {1'b0, limit_i}) begin
                acc_d  = wrapped[15:0];
                tick_d = 1'b1;
            end else begin
                acc_d = sum[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronizer, 16x oversampling FSM, {err,data} word out one clk after last stop sample.
// No backpressure: a word arriving while the FIFO is full is dropped and flagged as overrun.
module uart_rx_core import uart_pkg::*; #(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rxd,
    input  logic             cr_pbit,
    input  logic             cr_ptype,
    input  logic [1:0]       cr_sbit,
    input  logic [11:0]      cr_baud_freq,
    input  logic [15:0]      cr_baud_limit,
    input  logic             fifo_rx_full,
    output logic             rx_wr,
    output logic [DATA_BITS:0] rx_wdata,
    output logic             stat_parity_err,
    output logic             stat_frame_err,
    output logic             stat_overrun,
    output logic             rx_busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE/2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    rx_state_e              state_q;
    logic [SW-1:0]          s_q;
    logic [BW-1:0]          b_q;
    logic [1:0]             k_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   pbit_q, ptype_q;
    logic [1:0]             nstop_q;
    logic                   perr_q, ferr_q;
    logic                   armed_q;
    logic                   rx_wr_q, perr_pulse_q, ferr_pulse_q, ovr_pulse_q;
    logic [DATA_BITS:0]     rx_wdata_q;
    logic                   ferr_final;

    uart_baud_gen u_baud (
        .clk     (clk),
        .reset   (reset),
        .freq_i  (cr_baud_freq),
        .limit_i (cr_baud_limit),
        .tick_o  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end

    assign rxs        = sync_q[SYNC_STAGES-1];
    assign ferr_final = ferr_q | ~rxs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RX_IDLE;
            s_q          <= '0;
            b_q          <= '0;
            k_q          <= '0;
            data_q       <= '0;
            pbit_q       <= 1'b0;
            ptype_q      <= 1'b0;
            nstop_q      <= 2'd1;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            armed_q      <= 1'b0;
            rx_wr_q      <= 1'b0;
            rx_wdata_q   <= '0;
            perr_pulse_q <= 1'b0;
            ferr_pulse_q <= 1'b0;
            ovr_pulse_q  <= 1'b0;
        end else begin
            rx_wr_q      <= 1'b0;
            perr_pulse_q <= 1'b0;
            ferr_pulse_q <= 1'b0;
            ovr_pulse_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    // After a break the line must return high before a new start is accepted.
                    if (!rxs && armed_q) begin
                        pbit_q  <= cr_pbit;
                        ptype_q <= cr_ptype;
                        nstop_q <= stop_count(stop_sel_e'(cr_sbit));
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                        s_q     <= '0;
                        state_q <= RX_START;
                    end else if (rxs) begin
                        armed_q <= 1'b1;
                    end
                end
                RX_START: if (tick) begin
                    if (s_q == S_MID) begin
                        if (rxs) begin
                            state_q <= RX_IDLE;
                        end else begin
                            s_q     <= '0;
                            b_q     <= '0;
                            state_q <= RX_DATA;
                        end
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
                RX_DATA: if (tick) begin
                    if (s_q == S_LAST) begin
                        s_q         <= '0;
                        data_q[b_q] <= rxs;
                        b_q         <= b_q + 1'b1;
                        if (b_q == B_LAST) begin
                            k_q     <= '0;
                            state_q <= pbit_q ? RX_PARITY : RX_STOP;
                        end
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
                RX_PARITY: if (tick) begin
                    if (s_q == S_LAST) begin
                        s_q     <= '0;
                        perr_q  <= ((^data_q) ^ rxs) != ptype_q;
                        state_q <= RX_STOP;
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
                RX_STOP: if (tick) begin
                    if (s_q == S_LAST) begin
                        s_q    <= '0;
                        k_q    <= k_q + 1'b1;
                        ferr_q <= ferr_final;
                        if (k_q == nstop_q - 2'd1) begin
                            state_q      <= RX_IDLE;
                            armed_q      <= rxs;
                            rx_wr_q      <= !fifo_rx_full;
                            ovr_pulse_q  <= fifo_rx_full;
                            perr_pulse_q <= perr_q;
                            ferr_pulse_q <= ferr_final;
                            if (!fifo_rx_full) rx_wdata_q <= {perr_q | ferr_final, data_q};
                        end
                    end else begin
                        s_q <= s_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_wr           = rx_wr_q;
    assign rx_wdata        = rx_wdata_q;
    assign stat_parity_err = perr_pulse_q;
    assign stat_frame_err  = ferr_pulse_q;
    assign stat_overrun    = ovr_pulse_q;
    assign rx_busy         = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed frames with a scoreboard: expected words are queued per frame, a monitor pops on each output event.
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rxd = 1'b1;
    logic        cr_pbit = 1'b0;
    logic        cr_ptype = 1'b0;
    logic [1:0]  cr_sbit = 2'b00;
    logic [11:0] cr_baud_freq = 12'd576;
    logic [15:0] cr_baud_limit = 16'd15625;
    logic        fifo_rx_full = 1'b0;
    logic        rx_wr;
    logic [8:0]  rx_wdata;
    logic        stat_parity_err, stat_frame_err, stat_overrun, rx_busy;

    uart_rx_core dut (
        .clk             (clk),
        .reset           (reset),
        .rxd             (rxd),
        .cr_pbit         (cr_pbit),
        .cr_ptype        (cr_ptype),
        .cr_sbit         (cr_sbit),
        .cr_baud_freq    (cr_baud_freq),
        .cr_baud_limit   (cr_baud_limit),
        .fifo_rx_full    (fifo_rx_full),
        .rx_wr           (rx_wr),
        .rx_wdata        (rx_wdata),
        .stat_parity_err (stat_parity_err),
        .stat_frame_err  (stat_frame_err),
        .stat_overrun    (stat_overrun),
        .rx_busy         (rx_busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit         ovr;
        logic [8:0] w;
        bit         pe;
        bit         fe;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   bit_cyc = 434;
    int   tick_total = 0;

    always @(posedge clk) if (dut.u_baud.tick_o) tick_total <= tick_total + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input bit ovr, input logic [8:0] w, input bit pe, input bit fe);
        exp_t e;
        e.ovr = ovr; e.w = w; e.pe = pe; e.fe = fe;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (rx_wr || stat_overrun || stat_parity_err || stat_frame_err)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", {28'd0, rx_wr, stat_overrun, stat_parity_err, stat_frame_err}, 0);
            end else begin
                e = sb_q.pop_front();
                chk("rx_wr", rx_wr, !e.ovr);
                chk("stat_overrun", stat_overrun, e.ovr);
                if (!e.ovr) chk("rx_wdata", rx_wdata, e.w);
                chk("stat_parity_err", stat_parity_err, e.pe);
                chk("stat_frame_err", stat_frame_err, e.fe);
            end
        end
    end

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (bit_cyc) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input bit par_en, input bit par_v,
                        input int nstop, input logic [2:0] stopv);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par_en) drive_bit(par_v);
        for (int i = 0; i < nstop; i++) drive_bit(stopv[i]);
        rxd = 1'b1;
        repeat (2 * bit_cyc) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rx_wr"}, rx_wr, 0);
        chk({tag, "_rx_wdata"}, rx_wdata, 0);
        chk({tag, "_stats"}, {29'd0, stat_parity_err, stat_frame_err, stat_overrun}, 0);
        chk({tag, "_rx_busy"}, rx_busy, 0);
    endtask

    initial begin
        int t0;
        int dt;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset = 1'b0;
        repeat (2 * bit_cyc) @(negedge clk);

        // 115200 baud at 50 MHz, 8N1
        push(0, 9'h0A5, 0, 0);
        send(8'hA5, 0, 0, 1, 3'b111);

        t0 = tick_total;
        repeat (20000) @(negedge clk);
        dt = tick_total - t0;
        checks++;
        if (dt < 736 || dt > 738) begin
            errors++;
            $display("FAIL tick_rate actual=%0d required=736..738", dt);
        end

        // Fast baud for the remaining frames: one tick every 2 clks, 32 clks per bit
        cr_baud_freq = 12'd1;
        cr_baud_limit = 16'd2;
        bit_cyc = 32;
        pulse_reset();
        repeat (2 * bit_cyc) @(negedge clk);

        cr_pbit = 1'b1; cr_ptype = 1'b0;
        push(0, 9'h007, 0, 0);
        send(8'h07, 1, 1'b1, 1, 3'b111);
        push(0, 9'h107, 1, 0);
        send(8'h07, 1, 1'b0, 1, 3'b111);
        cr_ptype = 1'b1;
        push(0, 9'h007, 0, 0);
        send(8'h07, 1, 1'b0, 1, 3'b111);
        cr_pbit = 1'b0; cr_ptype = 1'b0;

        cr_sbit = 2'b01;
        push(0, 9'h15A, 0, 1);
        send(8'h5A, 0, 0, 2, 3'b101);
        cr_sbit = 2'b10;
        push(0, 9'h0C3, 0, 0);
        send(8'hC3, 0, 0, 3, 3'b111);
        cr_sbit = 2'b11;
        push(0, 9'h196, 0, 1);
        send(8'h96, 0, 0, 3, 3'b011);
        cr_sbit = 2'b00;

        // False start: low for 4 ticks only
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        chk("false_start_busy", rx_busy, 1);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        chk("false_start_idle", rx_busy, 0);
        push(0, 9'h03C, 0, 0);
        send(8'h3C, 0, 0, 1, 3'b111);

        fifo_rx_full = 1'b1;
        push(1, 9'h000, 0, 0);
        send(8'h55, 0, 0, 1, 3'b111);
        fifo_rx_full = 1'b0;
        push(0, 9'h055, 0, 0);
        send(8'h55, 0, 0, 1, 3'b111);

        // Break: line held low well past one frame
        push(0, 9'h100, 0, 1);
        rxd = 1'b0;
        repeat (20 * bit_cyc) @(negedge clk);
        chk("break_idle", rx_busy, 0);
        rxd = 1'b1;
        repeat (2 * bit_cyc) @(negedge clk);
        push(0, 9'h0E1, 0, 0);
        send(8'hE1, 0, 0, 1, 3'b111);

        // Reset in the middle of DATA
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        chk("mid_data_busy", rx_busy, 1);
        reset = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        chk_outputs_zero("mid_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2 * bit_cyc) @(negedge clk);
        push(0, 9'h081, 0, 0);
        send(8'h81, 0, 0, 1, 3'b111);

        // Limit of zero: no ticks, FSM parks in START
        cr_baud_limit = 16'd0;
        repeat (4) @(negedge clk);
        t0 = tick_total;
        rxd = 1'b0;
        repeat (300) @(negedge clk);
        chk("limit0_ticks", tick_total - t0, 0);
        chk("limit0_in_start", rx_busy, 1);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        cr_baud_limit = 16'd2;
        repeat (100) @(negedge clk);
        chk("limit0_recover_idle", rx_busy, 0);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
